// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 4-digit seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Entry n is the active-low pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit k is a leading zero when nibbles k..3 are all zero.
  // Digit 0 always shows.
  function automatic logic digit_lz_blank(
    input logic [15:0] shown,
    input logic [1:0]  k
  );
    logic r;
    r = 1'b0;
    case (k)
      2'd1:    r = (shown[15:4] == 12'h000);
      2'd2:    r = (shown[15:8] == 8'h00);
      2'd3:    r = (shown[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Output order is {g,f,e,d,c,b,a}.
module hex_seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with
// frame-aligned value latching, anti-ghost blanking and zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE     = 100_000,
  parameter int BLANK_CYCLES = 2_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic        pending,
  output logic        frame_tick,
  output logic [1:0]  refresh_count,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] PC_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;
  logic [15:0]   shown;
  logic [15:0]   pend_value;
  logic          wrap;
  logic          boundary;
  logic          in_blank;
  logic          lz;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  assign wrap     = (pcnt == PC_LAST);
  assign boundary = wrap && (refresh_count == 2'd3);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pcnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign nibble = shown[{refresh_count, 2'b00} +: 4];
  assign lz     = blank_lz && digit_lz_blank(shown, refresh_count);

  hex_seg7_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Scan counters and frame-aligned value latching
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt          <= '0;
      refresh_count <= 2'd0;
      shown         <= 16'h0000;
      pend_value    <= 16'h0000;
      pending       <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      pcnt       <= wrap ? '0 : pcnt + CW'(1);
      frame_tick <= 1'b0;
      if (wrap) begin
        refresh_count <= refresh_count + 2'd1;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shown      <= value;
          frame_tick <= 1'b1;
        end else if (pending) begin
          shown      <= pend_value;
          frame_tick <= 1'b1;
        end
      end else if (load) begin
        pend_value <= value;
        pending    <= 1'b1;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (in_blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << refresh_count);
      seg <= lz ? SEG_OFF : dec_seg;
      dp  <= ~dp_mask[refresh_count];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a cycle-count based
// reference model and hand-computed spot checks.
module tb_seg7_scan_driver;

  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic        pending;
  logic        frame_tick;
  logic [1:0]  refresh_count;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .value         (value),
    .blank_lz      (blank_lz),
    .dp_mask       (dp_mask),
    .pending       (pending),
    .frame_tick    (frame_tick),
    .refresh_count (refresh_count),
    .an            (an),
    .seg           (seg),
    .dp            (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int passed = 0;
  int total  = 0;
  int ft_seen = 0;

  int          t;
  int          p_slot;
  int          p_pc;
  logic [15:0] m_shown;
  logic [15:0] m_pv;
  logic        m_pend;
  logic        m_ft;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (t=%0d)", name, act, exp, t);
  endtask

  task automatic step();
    int pc;
    int sl;
    logic [15:0] hi;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_shown = 0; m_pv = 0; m_pend = 0; m_ft = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      p_slot = -1; p_pc = -1;
    end else begin
      pc = t % P;
      sl = (t / P) % 4;
      p_slot = sl;
      p_pc = pc;
      hi = m_shown >> (4 * sl);
      if (pc < B) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = 4'hF ^ (4'b0001 << sl);
        e_seg = (blank_lz && sl != 0 && hi == 0) ? 7'h7F : tbl[hi[3:0]];
        e_dp = !dp_mask[sl];
      end
      m_ft = 1'b0;
      if (pc == P - 1 && sl == 3) begin
        if (load) begin m_shown = value; m_ft = 1'b1; end
        else if (m_pend) begin m_shown = m_pv; m_ft = 1'b1; end
        m_pend = 1'b0;
      end else if (load) begin
        m_pv = value; m_pend = 1'b1;
      end
      t++;
    end
    #1;
    chk("refresh_count", 16'(refresh_count), 16'((t / P) % 4));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("frame_tick", 16'(frame_tick), 16'(m_ft));
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    if (frame_tick) ft_seen++;
  endtask

  // Advance until the outputs reflect the state (slot s, prescale p).
  task automatic goto(input int s, input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(p_slot == s && p_pc == p) && n < 4 * P + 2);
    if (!(p_slot == s && p_pc == p)) begin
      total++;
      $display("FAIL goto: slot %0d pc %0d not reached, want %0d/%0d",
               p_slot, p_pc, s, p);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0;
    blank_lz = 1'b0; dp_mask = 4'h0;
    step(); step();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    rst_n = 1'b1;

    step();
    chk("first_an", 16'(an), 16'hF);
    goto(0, 1); chk("idle_blank_an", 16'(an), 16'hF);
    goto(0, 2); chk("idle_an0", 16'(an), 16'hE);
    goto(2, 5); chk("idle_an2", 16'(an), 16'hB);
    chk("idle_seg", 16'(seg), 16'h40);
    goto(3, 7);

    goto(1, 3);
    load = 1'b1; value = 16'h12AF;
    step();
    load = 1'b0;
    chk("lp_pending", 16'(pending), 16'h1);
    goto(3, 7); chk("lp_tick", 16'(frame_tick), 16'h1);
    chk("lp_pend_clr", 16'(pending), 16'h0);
    goto(0, 4); chk("lp_s0", 16'(seg), 16'h0E);
    goto(1, 4); chk("lp_s1", 16'(seg), 16'h08);
    goto(2, 4); chk("lp_s2", 16'(seg), 16'h24);
    goto(3, 4); chk("lp_s3", 16'(seg), 16'h79);
    chk("lp_an3", 16'(an), 16'h7);

    goto(0, 5);
    ft_seen = 0;
    load = 1'b1; value = 16'h1111; step(); load = 1'b0;
    goto(2, 1);
    load = 1'b1; value = 16'h2222; step(); load = 1'b0;
    goto(3, 7);
    goto(1, 4);
    chk("two_ticks", 16'(ft_seen), 16'h1);
    chk("two_s1", 16'(seg), 16'h24);

    goto(3, 6);
    load = 1'b1; value = 16'h0005; step(); load = 1'b0;
    chk("bnd_pending", 16'(pending), 16'h0);
    chk("bnd_tick", 16'(frame_tick), 16'h1);
    goto(0, 4); chk("bnd_s0", 16'(seg), 16'h12);
    goto(1, 4); chk("bnd_s1", 16'(seg), 16'h40);

    goto(2, 0);
    load = 1'b1; value = 16'h0050; step(); load = 1'b0;
    goto(3, 7);
    blank_lz = 1'b1; dp_mask = 4'b1000;
    goto(0, 4); chk("lz_s0", 16'(seg), 16'h40);
    chk("lz_dp0", 16'(dp), 16'h1);
    goto(1, 4); chk("lz_s1", 16'(seg), 16'h12);
    goto(2, 4); chk("lz_s2", 16'(seg), 16'h7F);
    chk("lz_an2", 16'(an), 16'hB);
    goto(3, 4); chk("lz_s3", 16'(seg), 16'h7F);
    chk("lz_dp3", 16'(dp), 16'h0);
    chk("lz_an3", 16'(an), 16'h7);
    goto(3, 7);

    blank_lz = 1'b0; dp_mask = 4'h0;
    goto(1, 2);
    load = 1'b1; value = 16'hABCD; step(); load = 1'b0;
    chk("mr_pending", 16'(pending), 16'h1);
    goto(2, 3);
    rst_n = 1'b0; step();
    chk("mr_an", 16'(an), 16'hF);
    chk("mr_seg", 16'(seg), 16'h7F);
    chk("mr_pending0", 16'(pending), 16'h0);
    chk("mr_rc", 16'(refresh_count), 16'h0);
    rst_n = 1'b1;
    goto(3, 7);
    chk("mr_notick", 16'(frame_tick), 16'h0);
    goto(0, 4); chk("mr_s0", 16'(seg), 16'h40);
    goto(3, 4); chk("mr_s3", 16'(seg), 16'h40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
